// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP 8-bit control unit: opcode values, T-state
// constants, control-word bit positions and the per-opcode last-step table.
// No ports; imported by control_decode and control_sequencer.
// -----------------------------------------------------------------------------
package sap_pkg;

   localparam int OPCODE_W = 4;
   localparam int STEP_W   = 3;

   // Opcodes (upper nibble of IR)
   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_STA = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_LDI = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_JC  = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_INC = 4'h9;
   localparam logic [OPCODE_W-1:0] OP_DEC = 4'hA;
   localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

   // T-states
   localparam logic [STEP_W-1:0] T0 = 3'd0;
   localparam logic [STEP_W-1:0] T1 = 3'd1;
   localparam logic [STEP_W-1:0] T2 = 3'd2;
   localparam logic [STEP_W-1:0] T3 = 3'd3;
   localparam logic [STEP_W-1:0] T4 = 3'd4;

   // Control-word bit indices
   localparam int CW_PC_OUT     = 0;
   localparam int CW_PC_INC     = 1;
   localparam int CW_PC_LOAD    = 2;
   localparam int CW_MAR_LOAD   = 3;
   localparam int CW_RAM_OUT    = 4;
   localparam int CW_RAM_LOAD   = 5;
   localparam int CW_IR_LOAD    = 6;
   localparam int CW_IR_OUT     = 7;
   localparam int CW_A_LOAD     = 8;
   localparam int CW_A_OUT      = 9;
   localparam int CW_B_LOAD     = 10;
   localparam int CW_ALU_ENABLE = 11;
   localparam int CW_SUB        = 12;
   localparam int CW_INC_A      = 13;
   localparam int CW_DEC_A      = 14;
   localparam int CW_FLAGS_LOAD = 15;
   localparam int CW_OUT_LOAD   = 16;
   localparam int CW_W          = 17;

   typedef logic [CW_W-1:0] ctrl_word_t;

   // Final T-state of each instruction; undefined opcodes run as NOP.
   function automatic logic [STEP_W-1:0] last_step_of(input logic [OPCODE_W-1:0] op);
      logic [STEP_W-1:0] ls;
      case (op)
         OP_LDA, OP_STA: ls = T3;
         OP_ADD, OP_SUB: ls = T4;
         default:        ls = T2;
      endcase
      return ls;
   endfunction

endpackage

// File: rtl/control_decode.sv
// -----------------------------------------------------------------------------
// control_decode
// Purely combinational microcode decode: maps (step, opcode, flags, halted) to
// the SAP control word and reports the instruction's final T-state.
// Ports:
//   step       in   current T-state
//   opcode     in   IR[7:4], only consulted from T2 onward
//   c_flag     in   registered carry (JC)
//   z_flag     in   registered zero (JZ)
//   halted     in   sticky halt; forces an all-zero control word
//   cw         out  control word, bit positions from sap_pkg
//   last_step  out  final T-state of the current opcode
// -----------------------------------------------------------------------------
module control_decode
   import sap_pkg::*;
(
   input  logic [STEP_W-1:0]   step,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                c_flag,
   input  logic                z_flag,
   input  logic                halted,
   output ctrl_word_t          cw,
   output logic [STEP_W-1:0]   last_step
);

   always_comb begin
      cw        = '0;
      last_step = last_step_of(opcode);
      if (!halted) begin
         case (step)
            T0: begin
               cw[CW_PC_OUT]   = 1'b1;
               cw[CW_MAR_LOAD] = 1'b1;
            end
            T1: begin
               cw[CW_RAM_OUT] = 1'b1;
               cw[CW_IR_LOAD] = 1'b1;
               cw[CW_PC_INC]  = 1'b1;
            end
            T2: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     cw[CW_IR_OUT]   = 1'b1;
                     cw[CW_MAR_LOAD] = 1'b1;
                  end
                  OP_LDI: begin
                     cw[CW_IR_OUT] = 1'b1;
                     cw[CW_A_LOAD] = 1'b1;
                  end
                  OP_JMP: begin
                     cw[CW_IR_OUT]  = 1'b1;
                     cw[CW_PC_LOAD] = 1'b1;
                  end
                  // Conditional jumps still drive the operand; only the load is gated.
                  OP_JC: begin
                     cw[CW_IR_OUT]  = 1'b1;
                     cw[CW_PC_LOAD] = c_flag;
                  end
                  OP_JZ: begin
                     cw[CW_IR_OUT]  = 1'b1;
                     cw[CW_PC_LOAD] = z_flag;
                  end
                  OP_INC: begin
                     cw[CW_INC_A]      = 1'b1;
                     cw[CW_ALU_ENABLE] = 1'b1;
                     cw[CW_A_LOAD]     = 1'b1;
                     cw[CW_FLAGS_LOAD] = 1'b1;
                  end
                  OP_DEC: begin
                     cw[CW_DEC_A]      = 1'b1;
                     cw[CW_ALU_ENABLE] = 1'b1;
                     cw[CW_A_LOAD]     = 1'b1;
                     cw[CW_FLAGS_LOAD] = 1'b1;
                  end
                  OP_OUT: begin
                     cw[CW_A_OUT]    = 1'b1;
                     cw[CW_OUT_LOAD] = 1'b1;
                  end
                  default: ;
               endcase
            end
            T3: begin
               case (opcode)
                  OP_LDA: begin
                     cw[CW_RAM_OUT] = 1'b1;
                     cw[CW_A_LOAD]  = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     cw[CW_RAM_OUT] = 1'b1;
                     cw[CW_B_LOAD]  = 1'b1;
                  end
                  OP_STA: begin
                     cw[CW_A_OUT]    = 1'b1;
                     cw[CW_RAM_LOAD] = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  cw[CW_ALU_ENABLE] = 1'b1;
                  cw[CW_A_LOAD]     = 1'b1;
                  cw[CW_FLAGS_LOAD] = 1'b1;
                  cw[CW_SUB]        = (opcode == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Microcoded control unit for the SAP 8-bit processor. Holds the T-state
// counter and the sticky halt flag, and fans the decoded control word out to
// the ALU and bus agents.
// Ports:
//   clk, rst_n                        clock (rising edge), async active-low reset
//   opcode                            IR[7:4], valid from T2
//   c_flag, z_flag                    registered ALU flags
//   pc_out, pc_inc, pc_load           program counter strobes
//   mar_load                          MAR load
//   ram_out, ram_load                 RAM drive / write
//   ir_load, ir_out                   IR load / operand drive
//   a_load, a_out, b_load             A and B register strobes
//   alu_enable, sub, inc_a, dec_a     ALU controls
//   flags_load                        flags register capture
//   out_load                          output register load
//   halt                              sticky halted status
//   step                              current T-state (debug)
// -----------------------------------------------------------------------------
module control_sequencer
   import sap_pkg::*;
#(
   parameter int OPCODE_W  = 4,
   parameter int NUM_STEPS = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                c_flag,
   input  logic                z_flag,
   output logic                pc_out,
   output logic                pc_inc,
   output logic                pc_load,
   output logic                mar_load,
   output logic                ram_out,
   output logic                ram_load,
   output logic                ir_load,
   output logic                ir_out,
   output logic                a_load,
   output logic                a_out,
   output logic                b_load,
   output logic                alu_enable,
   output logic                sub,
   output logic                inc_a,
   output logic                dec_a,
   output logic                flags_load,
   output logic                out_load,
   output logic                halt,
   output logic [2:0]          step
);

   localparam logic [STEP_W-1:0] MAX_STEP = STEP_W'(NUM_STEPS - 1);

   logic [STEP_W-1:0] step_q;
   logic              halted_q;
   ctrl_word_t        cw;
   logic [STEP_W-1:0] last_step;

   control_decode u_decode (
      .step      (step_q),
      .opcode    (opcode),
      .c_flag    (c_flag),
      .z_flag    (z_flag),
      .halted    (halted_q),
      .cw        (cw),
      .last_step (last_step)
   );

   // HLT parks the counter at T2; the MAX_STEP bound keeps step in 0..4 even
   // if the last-step table were ever widened.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else if (!halted_q) begin
         if (step_q == T2 && opcode == OP_HLT) begin
            halted_q <= 1'b1;
         end else if (step_q >= last_step || step_q >= MAX_STEP) begin
            step_q <= T0;
         end else begin
            step_q <= step_q + 3'd1;
         end
      end
   end

   assign pc_out     = cw[CW_PC_OUT];
   assign pc_inc     = cw[CW_PC_INC];
   assign pc_load    = cw[CW_PC_LOAD];
   assign mar_load   = cw[CW_MAR_LOAD];
   assign ram_out    = cw[CW_RAM_OUT];
   assign ram_load   = cw[CW_RAM_LOAD];
   assign ir_load    = cw[CW_IR_LOAD];
   assign ir_out     = cw[CW_IR_OUT];
   assign a_load     = cw[CW_A_LOAD];
   assign a_out      = cw[CW_A_OUT];
   assign b_load     = cw[CW_B_LOAD];
   assign alu_enable = cw[CW_ALU_ENABLE];
   assign sub        = cw[CW_SUB];
   assign inc_a      = cw[CW_INC_A];
   assign dec_a      = cw[CW_DEC_A];
   assign flags_load = cw[CW_FLAGS_LOAD];
   assign out_load   = cw[CW_OUT_LOAD];
   assign halt       = halted_q;
   assign step       = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer: an instruction-level model
// compared every cycle, plus directed literal expectations.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

   logic       clk;
   logic       rst_n;
   logic [3:0] opcode;
   logic       c_flag;
   logic       z_flag;
   logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
   logic a_load, a_out, b_load, alu_enable, sub, inc_a, dec_a, flags_load, out_load;
   logic       halt;
   logic [2:0] step;

   control_sequencer #(.OPCODE_W(4), .NUM_STEPS(5)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .c_flag(c_flag), .z_flag(z_flag),
      .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
      .ram_out(ram_out), .ram_load(ram_load), .ir_load(ir_load), .ir_out(ir_out),
      .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_enable(alu_enable),
      .sub(sub), .inc_a(inc_a), .dec_a(dec_a), .flags_load(flags_load),
      .out_load(out_load), .halt(halt), .step(step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe masks in the bench's own packing order
   localparam logic [16:0] M_PC_OUT   = 17'h10000;
   localparam logic [16:0] M_PC_INC   = 17'h08000;
   localparam logic [16:0] M_PC_LOAD  = 17'h04000;
   localparam logic [16:0] M_MAR_LOAD = 17'h02000;
   localparam logic [16:0] M_RAM_OUT  = 17'h01000;
   localparam logic [16:0] M_RAM_LOAD = 17'h00800;
   localparam logic [16:0] M_IR_LOAD  = 17'h00400;
   localparam logic [16:0] M_IR_OUT   = 17'h00200;
   localparam logic [16:0] M_A_LOAD   = 17'h00100;
   localparam logic [16:0] M_A_OUT    = 17'h00080;
   localparam logic [16:0] M_B_LOAD   = 17'h00040;
   localparam logic [16:0] M_ALU      = 17'h00020;
   localparam logic [16:0] M_SUB      = 17'h00010;
   localparam logic [16:0] M_INC_A    = 17'h00008;
   localparam logic [16:0] M_DEC_A    = 17'h00004;
   localparam logic [16:0] M_FLAGS    = 17'h00002;
   localparam logic [16:0] M_OUT_LOAD = 17'h00001;

   logic [16:0] dut_cw;
   assign dut_cw = {pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load,
                    ir_out, a_load, a_out, b_load, alu_enable, sub, inc_a, dec_a,
                    flags_load, out_load};

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Instruction lengths in cycles, written out by hand (0xF halts, listed as 3)
   int len_lit [16] = '{3, 4, 5, 5, 4, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};

   // ---------------- instruction-level model ----------------
   function automatic int model_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   function automatic logic [16:0] model_cw(input int t, input logic [3:0] op,
                                            input logic c, input logic z, input bit hl);
      if (hl)     return '0;
      if (t == 0) return M_PC_OUT | M_MAR_LOAD;
      if (t == 1) return M_RAM_OUT | M_IR_LOAD | M_PC_INC;
      case (op)
         4'h1: return (t == 2) ? (M_IR_OUT | M_MAR_LOAD) : (t == 3) ? (M_RAM_OUT | M_A_LOAD) : '0;
         4'h2: return (t == 2) ? (M_IR_OUT | M_MAR_LOAD) : (t == 3) ? (M_RAM_OUT | M_B_LOAD)
                    : (t == 4) ? (M_ALU | M_A_LOAD | M_FLAGS) : '0;
         4'h3: return (t == 2) ? (M_IR_OUT | M_MAR_LOAD) : (t == 3) ? (M_RAM_OUT | M_B_LOAD)
                    : (t == 4) ? (M_ALU | M_A_LOAD | M_FLAGS | M_SUB) : '0;
         4'h4: return (t == 2) ? (M_IR_OUT | M_MAR_LOAD) : (t == 3) ? (M_A_OUT | M_RAM_LOAD) : '0;
         4'h5: return (t == 2) ? (M_IR_OUT | M_A_LOAD) : '0;
         4'h6: return (t == 2) ? (M_IR_OUT | M_PC_LOAD) : '0;
         4'h7: return (t == 2) ? (M_IR_OUT | (c ? M_PC_LOAD : 17'h0)) : '0;
         4'h8: return (t == 2) ? (M_IR_OUT | (z ? M_PC_LOAD : 17'h0)) : '0;
         4'h9: return (t == 2) ? (M_INC_A | M_ALU | M_A_LOAD | M_FLAGS) : '0;
         4'hA: return (t == 2) ? (M_DEC_A | M_ALU | M_A_LOAD | M_FLAGS) : '0;
         4'hE: return (t == 2) ? (M_A_OUT | M_OUT_LOAD) : '0;
         default: return '0;
      endcase
   endfunction

   int m_cyc;
   bit m_halt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc  <= 0;
         m_halt <= 1'b0;
      end else if (!m_halt) begin
         if (m_cyc == 2 && opcode == 4'hF) m_halt <= 1'b1;
         else if (m_cyc >= model_len(opcode) - 1) m_cyc <= 0;
         else m_cyc <= m_cyc + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         logic [16:0] exp_cw;
         exp_cw = model_cw(m_cyc, opcode, c_flag, z_flag, m_halt);
         checks++;
         if (dut_cw !== exp_cw || step !== 3'(m_cyc) || halt !== m_halt) begin
            errors++;
            $display("FAIL model t=%0t op=%h cw=%h step=%0d halt=%b required cw=%h step=%0d halt=%b",
                     $time, opcode, dut_cw, step, halt, exp_cw, m_cyc, m_halt);
         end
         checks++;
         if ($countones({pc_out, ram_out, ir_out, a_out, alu_enable}) > 1 ||
             $countones({inc_a, dec_a, sub}) > 1 ||
             ((inc_a | dec_a | sub) && !alu_enable)) begin
            errors++;
            $display("FAIL invariant t=%0t cw=%h required legal driver/alu combination",
                     $time, dut_cw);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   logic [16:0] cap [8];

   // Starts with the DUT in T0; returns cycles until step is back at T0.
   // With junk set, a wrong opcode is presented during fetch.
   task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                            input bit junk, output int n);
      bit done;
      opcode = junk ? (op ^ 4'hA) : op;
      c_flag = c;
      z_flag = z;
      for (int i = 0; i < 8; i++) cap[i] = '0;
      cap[0] = dut_cw;
      n = 1;
      done = 1'b0;
      while (!done) begin
         @(posedge clk);
         #1;
         if (junk && n == 1) opcode = op;
         if (step == 3'd0) begin
            done = 1'b1;
         end else if (n >= 7) begin
            checks++;
            errors++;
            $display("FAIL timeout op=%h step=%0d required return to 0", op, step);
            done = 1'b1;
         end else begin
            cap[n] = dut_cw;
            n++;
         end
      end
   endtask

   int n;

   initial begin
      rst_n  = 1'b0;
      opcode = 4'h5;
      c_flag = 1'b0;
      z_flag = 1'b0;
      #3;
      chk("reset_step", 17'(step), 17'd0);
      chk("reset_halt", 17'(halt), 17'd0);
      chk("reset_cw", dut_cw, M_PC_OUT | M_MAR_LOAD);
      chk_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // LDI
      run_instr(4'h5, 1'b0, 1'b0, 1'b0, n);
      chk("ldi_len", 17'(n), 17'd3);
      chk("ldi_t0", cap[0], M_PC_OUT | M_MAR_LOAD);
      chk("ldi_t1", cap[1], M_RAM_OUT | M_IR_LOAD | M_PC_INC);
      chk("ldi_t2", cap[2], M_IR_OUT | M_A_LOAD);

      // SUB
      run_instr(4'h3, 1'b0, 1'b0, 1'b0, n);
      chk("sub_len", 17'(n), 17'd5);
      chk("sub_t3", cap[3], M_RAM_OUT | M_B_LOAD);
      chk("sub_t4", cap[4], M_ALU | M_SUB | M_A_LOAD | M_FLAGS);

      // JC not taken / taken
      run_instr(4'h7, 1'b0, 1'b1, 1'b0, n);
      chk("jc0_len", 17'(n), 17'd3);
      chk("jc0_t2", cap[2], M_IR_OUT);
      run_instr(4'h7, 1'b1, 1'b0, 1'b0, n);
      chk("jc1_len", 17'(n), 17'd3);
      chk("jc1_t2", cap[2], M_IR_OUT | M_PC_LOAD);

      // Asynchronous reset in the middle of ADD T3
      opcode = 4'h2;
      repeat (3) @(posedge clk);
      #1;
      chk("add_t3_step", 17'(step), 17'd3);
      chk("add_t3_bload", 17'(b_load), 17'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_step", 17'(step), 17'd0);
      chk("arst_cw", dut_cw, M_PC_OUT | M_MAR_LOAD);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_next_step", 17'(step), 17'd1);
      begin
         int w = 0;
         while (step != 3'd0 && w < 8) begin
            @(posedge clk);
            #1;
            w++;
         end
         chk("arst_recover", 17'(step), 17'd0);
      end

      // Sweep every non-halting opcode with both flag values
      for (int op = 0; op < 15; op++) begin
         for (int c = 0; c < 2; c++) begin
            logic cb;
            cb = 1'(c);
            run_instr(4'(op), cb, ~cb, 1'b1, n);
            chk($sformatf("len_op%h_c%0d", op, c), 17'(n), 17'(len_lit[op]));
            if (op >= 11 && op <= 13) chk($sformatf("undef_op%h_t2", op), cap[2], 17'h0);
         end
      end

      // HLT
      opcode = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      chk("hlt_t2_step", 17'(step), 17'd2);
      chk("hlt_t2_halt", 17'(halt), 17'd0);
      @(posedge clk);
      #1;
      chk("hlt_halt", 17'(halt), 17'd1);
      opcode = 4'h2;
      c_flag = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("hlt_frozen_step", 17'(step), 17'd2);
      chk("hlt_frozen_cw", dut_cw, 17'h0);
      chk("hlt_still", 17'(halt), 17'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("hlt_rst_halt", 17'(halt), 17'd0);
      chk("hlt_rst_step", 17'(step), 17'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(4'hE, 1'b0, 1'b0, 1'b0, n);
      chk("out_len", 17'(n), 17'd3);
      chk("out_t2", cap[2], M_A_OUT | M_OUT_LOAD);

      @(negedge clk);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
